// File: rtl/sequence_pattern_generator.sv
// -----------------------------------------------------------------------------
// sequence_pattern_generator
//
// Framed serial bit-pattern source. A pattern of up to MAX_LEN bits is
// captured on a start/ready handshake. It is then shifted out MSB-first
// (pattern[len-1] down to pattern[0]), one bit per clock. The pattern is
// emitted reps+1 times, with gap idle cycles between repetitions.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   transfer request, accepted when start && ready && !abort
//   ready    out  generator idle, able to accept start
//   pattern  in   [MAX_LEN-1:0] bits to send (active bits pattern[len-1:0])
//   len      in   [LEN_W-1:0] bits per repetition (clamped to MAX_LEN)
//   reps     in   [REP_W-1:0] extra repetitions (total = reps+1)
//   gap      in   [GAP_W-1:0] idle cycles between repetitions
//   abort    in   synchronous cancel of the current transfer
//   x        out  serial data bit (0 whenever x_valid is 0)
//   x_valid  out  x carries a pattern bit this cycle
//   busy     out  transfer in progress (always !ready)
//   done     out  one-cycle pulse on normal completion
//
// All outputs are registered. The combinational block computes the value
// each output must show in the *next* cycle, alongside the next state.
// -----------------------------------------------------------------------------
module sequence_pattern_generator #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int REP_W   = 4,
    parameter int GAP_W   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic               ready,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   reps,
    input  logic [GAP_W-1:0]   gap,
    input  logic               abort,
    output logic               x,
    output logic               x_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_LEN   = LEN_W'(1);
    localparam logic [REP_W-1:0] ONE_REP   = REP_W'(1);
    localparam logic [GAP_W-1:0] ONE_GAP   = GAP_W'(1);

    // Selects bit idx of a pattern. The shift form keeps the index width
    // independent of the pattern width.
    function automatic logic pick_bit(input logic [MAX_LEN-1:0] pat,
                                      input logic [LEN_W-1:0]   idx);
        logic [MAX_LEN-1:0] shifted;
        shifted = pat >> idx;
        return shifted[0];
    endfunction

    state_t              state_r,   state_s;
    logic [MAX_LEN-1:0]  pat_r,     pat_s;
    logic [LEN_W-1:0]    len_r,     len_s;
    logic [REP_W-1:0]    rep_r,     rep_s;
    logic [GAP_W-1:0]    gap_len_r, gap_len_s;
    logic [LEN_W-1:0]    bit_idx_r, bit_idx_s;
    logic [GAP_W-1:0]    gap_cnt_r, gap_cnt_s;
    logic                x_r,       x_s;
    logic                x_valid_r, x_valid_s;
    logic                ready_r,   ready_s;
    logic                busy_r;
    logic                done_r,    done_s;
    logic [LEN_W-1:0]    eff_len_s;

    // Clamp the requested length to the pattern register width.
    always_comb begin
        if (len > MAX_LEN_L) begin
            eff_len_s = MAX_LEN_L;
        end else begin
            eff_len_s = len;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s   = state_r;
        pat_s     = pat_r;
        len_s     = len_r;
        rep_s     = rep_r;
        gap_len_s = gap_len_r;
        bit_idx_s = bit_idx_r;
        gap_cnt_s = gap_cnt_r;
        x_s       = 1'b0;
        x_valid_s = 1'b0;
        ready_s   = 1'b0;
        done_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b1;
                // abort in IDLE blocks a simultaneous start
                if (start && !abort) begin
                    pat_s     = pattern;
                    len_s     = eff_len_s;
                    rep_s     = reps;
                    gap_len_s = gap;
                    gap_cnt_s = {GAP_W{1'b0}};
                    if (eff_len_s == {LEN_W{1'b0}}) begin
                        // Empty pattern: complete at once, emit nothing.
                        bit_idx_s = {LEN_W{1'b0}};
                        rep_s     = {REP_W{1'b0}};
                        done_s    = 1'b1;
                    end else begin
                        state_s   = ST_SHIFT;
                        bit_idx_s = eff_len_s - ONE_LEN;
                        x_s       = pick_bit(pattern, eff_len_s - ONE_LEN);
                        x_valid_s = 1'b1;
                        ready_s   = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    state_s   = ST_IDLE;
                    rep_s     = {REP_W{1'b0}};
                    bit_idx_s = {LEN_W{1'b0}};
                    gap_cnt_s = {GAP_W{1'b0}};
                    ready_s   = 1'b1;
                end else if (bit_idx_r != {LEN_W{1'b0}}) begin
                    bit_idx_s = bit_idx_r - ONE_LEN;
                    x_s       = pick_bit(pat_r, bit_idx_r - ONE_LEN);
                    x_valid_s = 1'b1;
                end else if (rep_r != {REP_W{1'b0}}) begin
                    rep_s = rep_r - ONE_REP;
                    if (gap_len_r != {GAP_W{1'b0}}) begin
                        state_s   = ST_GAP;
                        gap_cnt_s = gap_len_r;
                    end else begin
                        // Back-to-back repetition, no bubble.
                        bit_idx_s = len_r - ONE_LEN;
                        x_s       = pick_bit(pat_r, len_r - ONE_LEN);
                        x_valid_s = 1'b1;
                    end
                end else begin
                    state_s   = ST_IDLE;
                    gap_cnt_s = {GAP_W{1'b0}};
                    ready_s   = 1'b1;
                    done_s    = 1'b1;
                end
            end

            ST_GAP: begin
                if (abort) begin
                    state_s   = ST_IDLE;
                    rep_s     = {REP_W{1'b0}};
                    bit_idx_s = {LEN_W{1'b0}};
                    gap_cnt_s = {GAP_W{1'b0}};
                    ready_s   = 1'b1;
                end else if (gap_cnt_r <= ONE_GAP) begin
                    // Last gap cycle: the next cycle restarts the pattern.
                    state_s   = ST_SHIFT;
                    gap_cnt_s = {GAP_W{1'b0}};
                    bit_idx_s = len_r - ONE_LEN;
                    x_s       = pick_bit(pat_r, len_r - ONE_LEN);
                    x_valid_s = 1'b1;
                end else begin
                    gap_cnt_s = gap_cnt_r - ONE_GAP;
                end
            end

            default: begin
                state_s   = ST_IDLE;
                rep_s     = {REP_W{1'b0}};
                bit_idx_s = {LEN_W{1'b0}};
                gap_cnt_s = {GAP_W{1'b0}};
                ready_s   = 1'b1;
            end
        endcase
    end

    // State, captured transfer parameters, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            pat_r     <= {MAX_LEN{1'b0}};
            len_r     <= {LEN_W{1'b0}};
            rep_r     <= {REP_W{1'b0}};
            gap_len_r <= {GAP_W{1'b0}};
            bit_idx_r <= {LEN_W{1'b0}};
            gap_cnt_r <= {GAP_W{1'b0}};
            x_r       <= 1'b0;
            x_valid_r <= 1'b0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            pat_r     <= pat_s;
            len_r     <= len_s;
            rep_r     <= rep_s;
            gap_len_r <= gap_len_s;
            bit_idx_r <= bit_idx_s;
            gap_cnt_r <= gap_cnt_s;
            x_r       <= x_s;
            x_valid_r <= x_valid_s;
            ready_r   <= ready_s;
            busy_r    <= !ready_s;
            done_r    <= done_s;
        end
    end

    assign x       = x_r;
    assign x_valid = x_valid_r;
    assign ready   = ready_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_sequence_pattern_generator.sv
// -----------------------------------------------------------------------------
// tb_sequence_pattern_generator
//
// Directed bench for sequence_pattern_generator. For each transfer, a small
// reference model pushes the per-cycle expected output vector
// {x_valid, x, ready, busy, done} onto a queue. The vectors are popped and
// compared on each falling edge.
// -----------------------------------------------------------------------------
module tb_sequence_pattern_generator;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int REP_W   = 4;
    localparam int GAP_W   = 4;

    logic               clk;
    logic               reset_n;
    logic               start;
    logic               ready;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [REP_W-1:0]   reps;
    logic [GAP_W-1:0]   gap;
    logic               abort;
    logic               x;
    logic               x_valid;
    logic               busy;
    logic               done;

    int tests_run = 0;
    int tests_failed = 0;

    logic [4:0] exp_q[$];

    sequence_pattern_generator #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W), .GAP_W(GAP_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ready(ready),
        .pattern(pattern), .len(len), .reps(reps), .gap(gap),
        .abort(abort), .x(x), .x_valid(x_valid), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] mk(input logic xv, input logic xb,
                                      input logic rdy, input logic dn);
        return {xv, xb, rdy, ~rdy, dn};
    endfunction

    function automatic logic [4:0] observed();
        return {x_valid, x, ready, busy, done};
    endfunction

    task automatic check(input string tag, input logic [4:0] obs,
                         input logic [4:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed={xv,x,rdy,busy,done}=%b expected=%b",
                   tag, obs, expv);
        end
    endtask

    // Reference model: queues every output cycle of one transfer,
    // ending with the done cycle.
    task automatic model(input logic [15:0] pat, input int ln, input int rp,
                         input int gp);
        int eff;
        eff = (ln > MAX_LEN) ? MAX_LEN : ln;
        if (eff > 0) begin
            for (int r = 0; r <= rp; r++) begin
                for (int i = eff - 1; i >= 0; i--) exp_q.push_back(mk(1'b1, pat[i], 1'b0, 1'b0));
                if (r < rp) begin
                    for (int g = 0; g < gp; g++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
                end
            end
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1));
    endtask

    // Called at a falling edge: present a start and queue the expected stream.
    task automatic launch(input logic [15:0] pat, input int ln, input int rp,
                          input int gp);
        pattern = pat;
        len     = LEN_W'(ln);
        reps    = REP_W'(rp);
        gap     = GAP_W'(gp);
        start   = 1'b1;
        model(pat, ln, rp, gp);
    endtask

    // Drains the scoreboard one cycle per entry. A spurious start is
    // pulsed after cycle start_at, and abort is held after cycle abort_at.
    task automatic run(input string tag, input int start_at, input int abort_at);
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            abort = 1'b0;
            check($sformatf("%s_c%0d", tag, k), observed(), exp_q.pop_front());
            if (k == start_at) begin
                start   = 1'b1;
                pattern = 16'h003C;
                len     = 5'd8;
            end
            if (k == abort_at) abort = 1'b1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = 16'h0000;
        len     = 5'd0;
        reps    = 4'd0;
        gap     = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check("reset", observed(), mk(1'b0, 1'b0, 1'b1, 1'b0));
        reset_n = 1'b1;
        @(negedge clk);
        check("idle", observed(), mk(1'b0, 1'b0, 1'b1, 1'b0));

        // 1: 101, single emission
        launch(16'h0005, 3, 0, 0);
        run("t1", 0, 0);
        // 2: started in the done cycle, three back-to-back repetitions
        launch(16'h0005, 3, 2, 0);
        run("t2", 0, 0);
        // 3: two repetitions with a two-cycle gap
        launch(16'h0005, 3, 1, 2);
        run("t3", 0, 0);
        // 4a: empty pattern ignores reps and gap
        launch(16'h0005, 0, 3, 2);
        run("t4a", 0, 0);
        // 4b: length clamped to MAX_LEN
        launch(16'hA5A5, 20, 0, 0);
        run("t4b", 0, 0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
        run("post_done", 0, 0);

        // 5: ignored start while busy, then abort presented on the 3rd bit
        launch(16'h00C3, 8, 0, 0);
        exp_q.delete();
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
        run("t5", 1, 3);

        // abort in IDLE blocks a simultaneous start
        pattern = 16'h0005;
        len     = 5'd3;
        reps    = 4'd0;
        gap     = 4'd0;
        start   = 1'b1;
        abort   = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
        run("idle_abort", 0, 0);

        // 6: asynchronous reset mid-shift
        launch(16'h0005, 3, 0, 0);
        exp_q.delete();
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
        run("t6_pre", 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async", observed(), mk(1'b0, 1'b0, 1'b1, 1'b0));
        @(negedge clk);
        check("t6_held", observed(), mk(1'b0, 1'b0, 1'b1, 1'b0));
        reset_n = 1'b1;
        @(negedge clk);
        check("t6_nodone", observed(), mk(1'b0, 1'b0, 1'b1, 1'b0));
        launch(16'h0005, 3, 0, 0);
        run("t6_post", 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
